stream_pattern_gen: RTL and testbench

//   Parametrised AXI-Stream-style test-pattern source feeding the udp_top user write port (wr_data/valid/last/ready).

---
 rtl/stream_pattern_gen_if.sv | 13 +
 rtl/stream_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_stream_pattern_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pattern_gen_if.sv
// Beat stream carrying test-pattern data from the generator to its consumer.
// The master drives data/valid/last and the slave returns ready.
interface stream_pattern_gen_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/stream_pattern_gen.sv
// Paced test-pattern source: one burst of BURST_LEN beats per period, one beat per sample tick.
// Backpressure drops samples rather than stalling the pacing; drops and missed starts are counted.
module stream_pattern_gen #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned PERIOD_CYCLES = 125_000_000,
  parameter int unsigned SAMPLE_DIV    = 47,
  parameter int unsigned BURST_LEN     = 10,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                i_Sys_clk,
  input  logic                i_Rst_n,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic [DATA_W-1:0]   i_seed,
  stream_pattern_gen_if.master m_axis,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_drop_cnt,
  output logic [CNT_W-1:0]    o_miss_cnt
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned DW = $clog2(SAMPLE_DIV);
  localparam int unsigned IW = $clog2(BURST_LEN + 1);

  localparam logic [PW-1:0] PerMax  = PW'(PERIOD_CYCLES - 1);
  localparam logic [DW-1:0] DivMax  = DW'(SAMPLE_DIV - 1);
  localparam logic [IW-1:0] IdxLast = IW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IdxEnd  = IW'(BURST_LEN);
  localparam logic [31:0]   LfsrPoly = 32'h8020_0003;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       per_q, per_d;
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [31:0]         beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [CNT_W-1:0]    miss_q, miss_d;

  logic              ps, tick, accept, pending, sample, form, drop;
  logic [31:0]       seed32;
  logic [DATA_W-1:0] beat_val;

  always_comb begin
    ps      = (per_q == '0);
    tick    = (div_q == DivMax);
    accept  = valid_q & m_axis.ready;
    pending = valid_q & ~m_axis.ready;
    sample  = (state_q == StBurst) && tick && (idx_q < IdxEnd);
    form    = sample & ~pending;
    drop    = sample & pending;
    seed32  = 32'(i_seed);

    unique case (mode_q)
      2'd0: beat_val = DATA_W'(idx_q);
      2'd1: beat_val = DATA_W'(beat_cnt_q);
      2'd2: beat_val = DATA_W'(lfsr_q);
      2'd3: beat_val = seed_q;
    endcase

    per_d = (per_q == PerMax) ? '0 : per_q + PW'(1);
    // Divider realigns to the period so every burst has the same tick phase.
    div_d = ((per_d == '0) || tick) ? '0 : div_q + DW'(1);

    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    valid_d    = accept ? 1'b0 : valid_q;
    last_d     = last_q;
    drop_d     = drop_q;
    miss_d     = miss_q;

    unique case (state_q)
      StIdle: begin
        if (ps && i_enable) begin
          state_d = StBurst;
          mode_d  = i_mode;
          seed_d  = i_seed;
          idx_d   = '0;
          lfsr_d  = (seed32 == '0) ? 32'd1 : seed32;
        end
      end
      StBurst: begin
        if (ps && (miss_q != '1)) miss_d = miss_q + CNT_W'(1);
        if (sample) idx_d = idx_q + IW'(1);
        if (form) begin
          valid_d    = 1'b1;
          data_d     = beat_val;
          last_d     = (idx_q == IdxLast);
          beat_cnt_d = beat_cnt_q + 32'd1;
          lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrPoly : 32'd0);
        end
        if (drop) begin
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
          // Losing the final sample must still terminate the burst on the held beat.
          if (idx_q == IdxLast) last_d = 1'b1;
        end
        if (accept && last_q) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= StIdle;
      per_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      lfsr_q     <= 32'd1;
      beat_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      drop_q     <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
      miss_q     <= miss_d;
    end
  end

  assign m_axis.data  = data_q;
  assign m_axis.valid = valid_q;
  assign m_axis.last  = last_q;
  assign o_busy       = (state_q == StBurst);
  assign o_drop_cnt   = drop_q;
  assign o_miss_cnt   = miss_q;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Randomised bench for stream_pattern_gen against a cycle-indexed behavioural model
// that derives pacing from the absolute cycle number rather than counters.
module tb_stream_pattern_gen;

  localparam int unsigned DataW     = 32;
  localparam int unsigned Period    = 200;
  localparam int unsigned SampleDiv = 4;
  localparam int unsigned BurstLen  = 5;
  localparam int unsigned CntW      = 3;
  localparam int          CntMax    = (1 << CntW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en;
  logic [1:0]       mode;
  logic [DataW-1:0] seed;
  logic             busy;
  logic [CntW-1:0]  drop_cnt, miss_cnt;

  stream_pattern_gen_if #(.DATA_W(DataW)) axis ();

  stream_pattern_gen #(
    .DATA_W       (DataW),
    .PERIOD_CYCLES(Period),
    .SAMPLE_DIV   (SampleDiv),
    .BURST_LEN    (BurstLen),
    .CNT_W        (CntW)
  ) dut (
    .i_Sys_clk (clk),
    .i_Rst_n   (rst_n),
    .i_enable  (en),
    .i_mode    (mode),
    .i_seed    (seed),
    .m_axis    (axis),
    .o_busy    (busy),
    .o_drop_cnt(drop_cnt),
    .o_miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model state
  int          m_t;
  bit          m_busy, m_valid, m_last;
  logic [31:0] m_data, m_seed, m_lfsr, m_beats;
  int          m_idx, m_mode, m_drop, m_miss;

  logic [63:0] acc_q[$];
  bit          saw_last;
  int          n_valid_seen;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  task automatic model_reset();
    m_t = 0; m_busy = 0; m_valid = 0; m_last = 0; m_data = '0;
    m_seed = '0; m_lfsr = 32'd1; m_beats = '0; m_idx = 0; m_mode = 0;
    m_drop = 0; m_miss = 0;
  endtask

  task automatic model_step();
    int ph;
    bit ps, tick, acc, formed, old_last;
    ph       = m_t % Period;
    ps       = (ph == 0);
    tick     = ((ph % SampleDiv) == SampleDiv - 1);
    acc      = m_valid && axis.ready;
    old_last = m_last;
    formed   = 0;
    if (m_busy) begin
      if (ps) m_miss = sat_inc(m_miss);
      if (tick && m_idx < BurstLen) begin
        if (m_valid && !axis.ready) begin
          m_drop = sat_inc(m_drop);
          if (m_idx == BurstLen - 1) m_last = 1;
        end else begin
          formed = 1;
          case (m_mode)
            0:       m_data = 32'(m_idx);
            1:       m_data = m_beats;
            2:       m_data = m_lfsr;
            default: m_data = m_seed;
          endcase
          m_last  = (m_idx == BurstLen - 1);
          m_beats = m_beats + 1;
          m_lfsr  = lfsr_next(m_lfsr);
        end
        m_idx++;
      end
      if (acc && old_last) m_busy = 0;
    end else if (ps && en) begin
      m_busy = 1;
      m_mode = int'(mode);
      m_seed = seed;
      m_idx  = 0;
      m_lfsr = (seed == 0) ? 32'd1 : seed;
    end
    if (formed) m_valid = 1;
    else if (acc) m_valid = 0;
    m_t++;
  endtask

  task automatic step();
    if (axis.valid && axis.ready) begin
      acc_q.push_back(64'(axis.data));
      if (axis.last) saw_last = 1;
    end
    if (axis.valid) n_valid_seen++;
    model_step();
    @(posedge clk);
    #1;
    check("valid", axis.valid, m_valid);
    check("busy", busy, m_busy);
    if (m_valid) begin
      check("data", axis.data, m_data);
      check("last", axis.last, m_last);
    end
    check("drop_cnt", drop_cnt, m_drop);
    check("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic align_period();
    while ((m_t % Period) != 0) step();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst_valid", axis.valid, 0);
    check("rst_last", axis.last, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_miss", miss_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int guard;
    en = 1'b1; mode = 2'd0; seed = '0; axis.ready = 1'b1;
    #2;
    reset_dut();
    check("rst_data", axis.data, 0);

    // Mode 0 with free-flowing sink over two periods
    acc_q.delete();
    repeat (400) step();
    check("m0_beats", acc_q.size(), 10);
    for (int i = 0; i < 5; i++) check("m0_idx", acc_q.size() > i ? acc_q[i] : 64'hdead, i);
    check("m0_drop", drop_cnt, 0);
    check("m0_miss", miss_cnt, 0);

    // LFSR mode, seed 1 then seed 0
    mode = 2'd2; seed = 32'd1;
    acc_q.delete();
    repeat (200) step();
    check("lfsr0", acc_q.size() > 0 ? acc_q[0] : 64'hdead, 32'h0000_0001);
    check("lfsr1", acc_q.size() > 1 ? acc_q[1] : 64'hdead, 32'h8020_0003);
    check("lfsr2", acc_q.size() > 2 ? acc_q[2] : 64'hdead, lfsr_next(32'h8020_0003));
    seed = 32'd0;
    acc_q.delete();
    repeat (200) step();
    check("seed0", acc_q.size() > 0 ? acc_q[0] : 64'hdead, 32'h0000_0001);

    // Short stall holding beat 1
    mode = 2'd0;
    guard = 0;
    while (!(m_valid && m_data == 1 && m_mode == 0) && guard < 100) begin
      step();
      guard++;
    end
    check("wait_beat1", guard < 100, 1);
    axis.ready = 1'b0;
    saw_last = 0;
    repeat (6) begin
      step();
      check("hold_data", axis.data, 1);
      check("hold_valid", axis.valid, 1);
    end
    axis.ready = 1'b1;
    align_period();
    check("bp_drop", drop_cnt, 1);
    check("bp_last", saw_last, 1);

    // Long stall across a period start
    axis.ready = 1'b0;
    repeat (250) step();
    check("stall_miss", miss_cnt, 1);
    check("stall_drop", drop_cnt, 5);
    axis.ready = 1'b1;
    saw_last = 0;
    repeat (10) step();
    check("stall_last", saw_last, 1);
    align_period();

    // Enable gating
    en = 1'b0;
    n_valid_seen = 0;
    repeat (100) step();
    en = 1'b1;
    repeat (100) step();
    check("en_quiet", n_valid_seen, 0);
    repeat (40) step();
    check("en_burst", n_valid_seen, 5);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if ((c % 50) == 0) begin
        mode = 2'($urandom_range(0, 3));
        seed = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        en   = ($urandom_range(0, 9) < 8);
      end
      axis.ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Saturate both counters
    en = 1'b1;
    axis.ready = 1'b1;
    repeat (30) step();
    align_period();
    axis.ready = 1'b0;
    repeat (1700) step();
    check("miss_sat", miss_cnt, CntMax);
    check("drop_sat", drop_cnt, CntMax);
    axis.ready = 1'b1;
    repeat (30) step();

    // Asynchronous reset in the middle of a burst
    align_period();
    mode = 2'd0;
    repeat (200) step();
    repeat (10) step();
    check("pre_rst_busy", busy, 1);
    reset_dut();
    acc_q.delete();
    repeat (40) step();
    check("post_rst_first", acc_q.size() > 0 ? acc_q[0] : 64'hdead, 0);
    check("post_rst_beats", acc_q.size(), 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
